// File: rtl/idct_pkg.sv
// idct_pkg: shared state type, constants and pixel clip for the IDCT block sequencer
package idct_pkg;
    localparam int CW        = 32;
    localparam int PW        = 8;
    localparam int FIN_SHIFT = 14;
    localparam int DC_SHIFT  = 6;
    localparam int LEVEL     = 128;
    localparam int PMAX      = (1 << PW) - 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_e;

    function automatic logic [PW-1:0] clip8(input logic signed [CW-1:0] v);
        return (v < 0) ? '0 : (v > PMAX) ? '1 : v[PW-1:0];
    endfunction
endpackage

// File: rtl/idct_col_finish.sv
// idct_col_finish: final butterfly, shift, level shift and clip for one column
module idct_col_finish
    import idct_pkg::*;
(
    input  logic [9*CW-1:0]        dp_out_i,
    input  logic signed [CW-1:0]   dc_coef_i,
    input  logic                   dc_only_i,
    output logic [8*PW-1:0]        pix_o
);
    logic signed [CW-1:0] x [9];
    logic signed [CW-1:0] s [8];
    logic signed [CW-1:0] dc;

    // butterfly the datapath words into row sums, or use the DC shortcut for sparse columns
    always_comb begin
        for (int k = 0; k < 9; k++) x[k] = dp_out_i[k*CW +: CW];
        s[0] = x[7] + x[1];
        s[1] = x[3] + x[2];
        s[2] = x[0] + x[4];
        s[3] = x[8] + x[6];
        s[4] = x[8] - x[6];
        s[5] = x[0] - x[4];
        s[6] = x[3] - x[2];
        s[7] = x[7] - x[1];
        dc = ((dc_coef_i + 32) >>> DC_SHIFT) + LEVEL;
        for (int r = 0; r < 8; r++)
            pix_o[r*PW +: PW] = clip8(dc_only_i ? dc : (s[r] >>> FIN_SHIFT) + LEVEL);
    end
endmodule

// File: rtl/idct_block_sequencer.sv
// idct_block_sequencer: buffers an 8x8 block, runs columns through the datapath, streams pixels
module idct_block_sequencer
    import idct_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_data,
    input  logic             in_last,
    output logic [8*CW-1:0]  dp_in,
    input  logic [9*CW-1:0]  dp_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err_len
);
    state_e          state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [2:0]      col_q, col_d;
    logic [5:0]      oidx_q, oidx_d;
    logic            err_q, err_d;
    logic            ov_q, ov_d;
    logic            ol_q, ol_d;
    logic [PW-1:0]   od_q, od_d;
    logic [CW-1:0]   coef_q [64];
    logic [PW-1:0]   pix_q [64];
    logic [8*PW-1:0] pix;
    logic            dc_only;

    assign in_ready  = state_q == LOAD;
    assign busy      = state_q != LOAD;
    assign err_len   = err_q;
    assign out_valid = ov_q;
    assign out_last  = ol_q;
    assign out_data  = od_q;
    assign dc_only   = ~|dp_in[8*CW-1:CW];

    // present the current column to the datapath only while computing
    always_comb begin
        dp_in = '0;
        if (state_q == COMPUTE)
            for (int r = 0; r < 8; r++) dp_in[r*CW +: CW] = coef_q[{3'(r), col_q}];
    end

    idct_col_finish u_finish (
        .dp_out_i  (dp_out),
        .dc_coef_i (dp_in[CW-1:0]),
        .dc_only_i (dc_only),
        .pix_o     (pix)
    );

    // buffers: store coefficients (zero-filling a short block) and capture finished columns
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            for (int i = 0; i < 64; i++)
                if (i == int'(idx_q)) coef_q[i] <= in_data;
                else if (in_last && i > int'(idx_q)) coef_q[i] <= '0;
        if (state_q == COMPUTE)
            for (int r = 0; r < 8; r++) pix_q[{3'(r), col_q}] <= pix[r*PW +: PW];
    end

    // next-state: load beats, step columns, then drain pixels with a registered output stage
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        oidx_d  = oidx_q;
        err_d   = err_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        od_d    = od_q;
        case (state_q)
            LOAD: if (in_valid) begin
                idx_d = idx_q + 6'd1;
                if (in_last || &idx_q) begin
                    state_d = COMPUTE;
                    idx_d   = '0;
                    err_d   = err_q | (in_last != &idx_q);
                end
            end
            COMPUTE: begin
                col_d = col_q + 3'd1;
                if (&col_q) begin
                    state_d = DRAIN;
                    oidx_d  = '0;
                    ov_d    = 1'b1;
                    ol_d    = 1'b0;
                    od_d    = pix_q[0];
                end
            end
            DRAIN: if (out_ready) begin
                if (&oidx_q) begin
                    state_d = LOAD;
                    ov_d    = 1'b0;
                    ol_d    = 1'b0;
                end else begin
                    oidx_d = oidx_q + 6'd1;
                    od_d   = pix_q[oidx_d];
                    ol_d   = &oidx_d;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            col_q   <= '0;
            oidx_q  <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            oidx_q  <= oidx_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            od_q    <= od_d;
        end
    end
endmodule

// File: tb/tb_idct_block_sequencer.sv
// tb_idct_block_sequencer: directed checks of the block sequencer with a behavioural column datapath
module tb_idct_block_sequencer;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [31:0]  in_data = 0;
    logic         in_last = 0;
    logic [255:0] dp_in;
    logic [287:0] dp_out;
    logic         out_valid;
    logic         out_ready = 1;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         err_len;

    int errors = 0;
    int checks = 0;
    int blk [64];
    int dpw [8];

    idct_block_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .dp_in(dp_in), .dp_out(dp_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // stand-in column datapath: simple scaled words, x8 mixes rows 0 and 7
    always_comb begin
        for (int k = 0; k < 8; k++) dpw[k] = dp_in[k*32 +: 32];
        for (int k = 0; k < 8; k++) dp_out[k*32 +: 32] = dpw[k] * (k + 1) * 997;
        dp_out[256 +: 32] = (dpw[0] + dpw[7]) * 1500;
    end

    function automatic logic [7:0] clipb(input int v);
        return v < 0 ? 8'd0 : v > 255 ? 8'd255 : 8'(v);
    endfunction

    function automatic logic [7:0] exp_pix(input int r, input int c);
        int x [9];
        int s;
        bit dc = 1;
        for (int k = 1; k < 8; k++) if (blk[k*8+c] != 0) dc = 0;
        if (dc) return clipb(((blk[c] + 32) >>> 6) + 128);
        for (int k = 0; k < 8; k++) x[k] = blk[k*8+c] * (k + 1) * 997;
        x[8] = (blk[c] + blk[56+c]) * 1500;
        case (r)
            0: s = x[7] + x[1];
            1: s = x[3] + x[2];
            2: s = x[0] + x[4];
            3: s = x[8] + x[6];
            4: s = x[8] - x[6];
            5: s = x[0] - x[4];
            6: s = x[3] - x[2];
            default: s = x[7] - x[1];
        endcase
        return clipb((s >>> 14) + 128);
    endfunction

    task automatic rand_block();
        for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 1023)) - 512;
        for (int c = 0; c < 8; c++) if (blk[8+c] == 0) blk[8+c] = 7;
    endtask

    task automatic send_block(input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1;
            in_data  = blk[i];
            in_last  = last && (i == n - 1);
            if (i == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b need 1", in_ready); end
            end
            @(posedge clk);
        end
        #1;
        in_valid = 0;
        in_last  = 0;
        for (int i = n; i < 64; i++) blk[i] = 0;
    endtask

    task automatic recv_block(input bit toggle, input string name, output logic [7:0] first);
        int got = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [7:0] held = 0;
        logic [7:0] exp;
        first = 0;
        while (got < 64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            out_ready = toggle ? ~out_ready : 1'b1;
            #1;
            if (stalled && out_valid) begin
                checks++;
                if (out_data !== held) begin errors++; $display("FAIL %s stall_hold pix %0d got %0d need %0d", name, got, out_data, held); end
            end
            stalled = 0;
            if (out_valid && out_ready) begin
                exp = exp_pix(got / 8, got % 8);
                if (got == 0) first = out_data;
                checks++;
                if (out_data !== exp) begin errors++; $display("FAIL %s pix %0d got %0d need %0d", name, got, out_data, exp); end
                checks++;
                if (out_last !== (got == 63)) begin errors++; $display("FAIL %s last pix %0d got %b need %b", name, got, out_last, got == 63); end
                got++;
            end else if (out_valid) begin
                stalled = 1;
                held = out_data;
            end
        end
        out_ready = 1;
        checks++;
        if (got != 64) begin errors++; $display("FAIL %s beats got %0d need 64", name, got); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL %s extra_beat valid got %b need 0", name, out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s reload_ready got %b need 1", name, in_ready); end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst in_ready got %b need 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst out_valid got %b need 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst out_last got %b need 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst busy got %b need 0", busy); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rst err_len got %b need 0", err_len); end
        checks++; if (dp_in !== '0) begin errors++; $display("FAIL rst dp_in got %h need 0", dp_in); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_zero_block();
        logic [7:0] first;
        int k = 0;
        for (int i = 0; i < 64; i++) blk[i] = 0;
        send_block(64, 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero busy got %b need 1", busy); end
        while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        checks++; if (k + 1 != 9) begin errors++; $display("FAIL latency got %0d need 9", k + 1); end
        recv_block(0, "zero", first);
        checks++; if (first !== 8'd128) begin errors++; $display("FAIL zero first got %0d need 128", first); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL zero err_len got %b need 0", err_len); end
    endtask

    task automatic test_dc_shortcut();
        logic [7:0] first;
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = 64;
        send_block(64, 1);
        recv_block(0, "dc64", first);
        checks++; if (first !== 8'd129) begin errors++; $display("FAIL dc64 first got %0d need 129", first); end
    endtask

    task automatic test_clip();
        logic [7:0] first;
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = 65536;
        send_block(64, 1);
        recv_block(0, "clip_hi", first);
        checks++; if (first !== 8'd255) begin errors++; $display("FAIL clip_hi first got %0d need 255", first); end
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = -65536;
        send_block(64, 1);
        recv_block(0, "clip_lo", first);
        checks++; if (first !== 8'd0) begin errors++; $display("FAIL clip_lo first got %0d need 0", first); end
    endtask

    task automatic test_random_stall();
        logic [7:0] first;
        for (int b = 0; b < 3; b++) begin
            rand_block();
            send_block(64, 1);
            recv_block(1, "random", first);
        end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL random err_len got %b need 0", err_len); end
    endtask

    task automatic test_short_block();
        logic [7:0] first;
        rand_block();
        send_block(10, 1);
        recv_block(0, "short", first);
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short err_len got %b need 1", err_len); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] first;
        int k = 0;
        rand_block();
        send_block(64, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_comp out_valid got %b need 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_comp in_ready got %b need 1", in_ready); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rst_comp err_len got %b need 0", err_len); end
        @(negedge clk) rst_n = 1;
        rand_block();
        send_block(64, 1);
        recv_block(0, "after_rst_comp", first);
        rand_block();
        send_block(64, 1);
        while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_drain wait got %b need 1", out_valid); end
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drain out_valid got %b need 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_drain in_ready got %b need 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_drain busy got %b need 0", busy); end
        @(negedge clk) rst_n = 1;
        rand_block();
        send_block(64, 1);
        recv_block(1, "after_rst_drain", first);
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_dc_shortcut();
        test_clip();
        test_random_stall();
        test_short_block();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
